mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequences the single-port unified memory shared by instruction fetch and the MEM stage.
- Grants one requester at a time and drives a request/done handshake to variable-latency memory.
- Generates the stall enables for the fetch path and the EX/MEM pipeline register, which holds while its access is outstanding.
- Enters a sticky halted state on a committed halt or on a memory timeout.

Parameters:
- TIMEOUT, 64: maximum cycles in a WAIT state without mem_done before err is raised.
- CW, 7: width of the wait counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- if_req  in  1  fetch wants an instruction word
- if_addr  in  16  fetch address (PC)
- dm_rd  in  1  EX/MEM stage memRead
- dm_wr  in  1  EX/MEM stage memWrite
- dm_addr  in  16  EX/MEM memAddr
- dm_wdata  in  16  EX/MEM writeData
- dm_halt  in  1  EX/MEM halt flag
- mem_done  in  1  memory completed the issued access; rdata valid this cycle
- mem_rdata  in  16  memory read data
- mem_req  out  1  one-cycle access strobe
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  access address
- mem_wdata  out  16  write data
- if_stall  out  1  hold PC and IF/ID register
- dm_stall  out  1  drives the stall input of EX/MEM and all earlier pipeline registers
- if_valid  out  1  instruction word valid on if_rdata
- if_rdata  out  16  fetched word
- dm_valid  out  1  load/store completing; dm_rdata valid
- dm_rdata  out  16  load data
- halted  out  1  sticky; no further accesses issued
- err  out  1  sticky memory timeout flag

Behaviour:
- States: IDLE, DATA_WAIT, FETCH_WAIT, HALTED. A last_grant bit records DATA or FETCH.
- Reset (rst=0, asynchronous):
  - State is IDLE, last_grant is FETCH, wait counter is 0.
  - mem_req, mem_wr, mem_addr, mem_wdata, halted and err are all 0.
  - Any in-flight access is abandoned. A later mem_done is ignored because it arrives in IDLE.
- dreq = dm_rd | dm_wr. dm_rd and dm_wr both high is treated as a write.
- IDLE grant rule, evaluated each cycle:
  - If dm_halt=1 and dreq=0: go to HALTED.
  - Else if dreq=1 and (if_req=0 or last_grant=FETCH): grant DATA.
  - Else if if_req=1: grant FETCH.
  - Else: stay in IDLE.
  - Data has priority, except that a waiting fetch wins immediately after a data grant (starvation guard).
- Grant effect (registered, at the clock edge):
  - mem_req=1 for exactly one cycle.
  - mem_addr, mem_wr and mem_wdata are loaded from the granted requester (fetch: mem_wr=0, mem_wdata=0).
  - State becomes DATA_WAIT or FETCH_WAIT; last_grant is updated; the wait counter clears.
- mem_addr, mem_wr and mem_wdata hold their values until the next grant.
- WAIT states:
  - The wait counter increments every cycle that mem_done=0.
  - mem_done=1: pulse dm_valid or if_valid (combinational, same cycle) with dm_rdata/if_rdata = mem_rdata, then return to IDLE.
  - Counter reaches TIMEOUT with no mem_done: set err=1 and go to HALTED.
  - The earliest legal mem_done is the cycle after mem_req; a minimum access takes 2 cycles (grant edge to done).
- Stalls (combinational):
  - dm_stall = dreq & ~(state==DATA_WAIT & mem_done) | (state==HALTED & ~err ? 0 : err).
  - if_stall = (if_req & ~(state==FETCH_WAIT & mem_done)) | dm_stall | halted.
  - dm_stall deasserts in the mem_done cycle, so EX/MEM captures the next instruction on that edge.
- halt: dm_halt with dreq=0 in IDLE sets halted=1. HALTED issues no mem_req, ignores mem_done, and is exited only by reset.
- dm_valid/if_valid are 0 in all states except the matching WAIT state with mem_done=1.
- The first data cycle after reset with an idle fetch is granted to DATA.

Test Plan:
- Reset during FETCH_WAIT at cycle 3, memory returns mem_done at cycle 5 -> no if_valid, state IDLE, mem_req=0, halted=0, err=0.
- Load only: dm_rd=1, dm_addr=0x0040, mem_done 3 cycles after mem_req with rdata=0xBEEF -> one mem_req pulse with mem_addr=0x0040 and mem_wr=0; dm_stall=1 until the done cycle; dm_valid=1 and dm_rdata=0xBEEF in that cycle.
- Simultaneous if_req (0x0010) and dm_wr (addr 0x0100, data 0x1234) from reset, 1-cycle memory -> DATA granted first with mem_wr=1 and mem_wdata=0x1234; the next grant is FETCH at 0x0010. if_stall stays 1 throughout the data access.
- Continuous dm_rd and if_req for 6 accesses -> grants alternate D, F, D, F, D, F; no requester is denied twice in a row.
- No mem_done for TIMEOUT=64 cycles in DATA_WAIT -> err=1 and halted=1 at the 64th cycle; no further mem_req; stalls held high.
- dm_halt=1 with dreq=0 while if_req=1 -> HALTED, halted=1, if_stall=1, zero further mem_req over 20 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Unified-memory port arbiter shared by instruction fetch and the MEM stage.
// One access in flight at a time; drives pipeline stalls and a sticky halt.
module mem_port_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    input  logic        dm_halt,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        if_stall,
    output logic        dm_stall,
    output logic        if_valid,
    output logic [15:0] if_rdata,
    output logic        dm_valid,
    output logic [15:0] dm_rdata,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        DATA_WAIT,
        FETCH_WAIT,
        HALTED
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic          lastGrantFetch;
    logic          lastGrantFetchNext;
    logic [CW-1:0] waitCnt;
    logic [CW-1:0] waitCntNext;
    logic          errNext;
    logic          memReqNext;
    logic          memWrNext;
    logic [15:0]   memAddrNext;
    logic [15:0]   memWdataNext;

    logic dreq;
    logic goHalt;
    logic grantData;
    logic grantFetch;
    logic timedOut;
    logic dataDone;
    logic fetchDone;

    assign dreq = dm_rd | dm_wr;

    // Fetch wins over data only right after a data grant.
    assign goHalt     = dm_halt & ~dreq;
    assign grantData  = dreq & (~if_req | lastGrantFetch);
    assign grantFetch = if_req & ~goHalt & ~grantData;

    assign timedOut  = ~mem_done & (waitCnt == CW'(TIMEOUT - 1));
    assign dataDone  = (state == DATA_WAIT) & mem_done;
    assign fetchDone = (state == FETCH_WAIT) & mem_done;

    always_comb begin
        stateNext          = state;
        lastGrantFetchNext = lastGrantFetch;
        waitCntNext        = waitCnt;
        errNext            = err;
        memReqNext         = 1'b0;
        memWrNext          = mem_wr;
        memAddrNext        = mem_addr;
        memWdataNext       = mem_wdata;
        case (state)
            IDLE: begin
                unique case (1'b1)
                    goHalt: stateNext = HALTED;
                    grantData: begin
                        stateNext          = DATA_WAIT;
                        lastGrantFetchNext = 1'b0;
                        waitCntNext        = '0;
                        memReqNext         = 1'b1;
                        memWrNext          = dm_wr;
                        memAddrNext        = dm_addr;
                        memWdataNext       = dm_wdata;
                    end
                    grantFetch: begin
                        stateNext          = FETCH_WAIT;
                        lastGrantFetchNext = 1'b1;
                        waitCntNext        = '0;
                        memReqNext         = 1'b1;
                        memWrNext          = 1'b0;
                        memAddrNext        = if_addr;
                        memWdataNext       = '0;
                    end
                    default: ;
                endcase
            end
            DATA_WAIT, FETCH_WAIT: begin
                if (mem_done) begin
                    stateNext = IDLE;
                end else if (timedOut) begin
                    stateNext = HALTED;
                    errNext   = 1'b1;
                end else begin
                    waitCntNext = waitCnt + CW'(1);
                end
            end
            HALTED: ;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            lastGrantFetch <= 1'b1;
            waitCnt        <= '0;
            err            <= 1'b0;
            mem_req        <= 1'b0;
            mem_wr         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
        end else begin
            state          <= stateNext;
            lastGrantFetch <= lastGrantFetchNext;
            waitCnt        <= waitCntNext;
            err            <= errNext;
            mem_req        <= memReqNext;
            mem_wr         <= memWrNext;
            mem_addr       <= memAddrNext;
            mem_wdata      <= memWdataNext;
        end
    end

    assign halted   = (state == HALTED);
    assign dm_valid = dataDone;
    assign if_valid = fetchDone;
    assign dm_rdata = mem_rdata;
    assign if_rdata = mem_rdata;

    // The MEM stage is released in its done cycle so EX/MEM advances on that edge.
    assign dm_stall = (dreq & ~dataDone) | err;
    assign if_stall = (if_req & ~fetchDone) | dm_stall | halted;

endmodule
